// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline register with stall counter and synchronous flush.
// Define PIPE_SKID_REG_SKID_EN to add the skid register, the FULL state and a registered in_ready.
module pipe_skid_reg #(
  parameter int DATA_W       = 32,
  parameter int CNT_W        = 16,
  parameter bit CLR_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] out_data_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;
  logic              accept, pop;

  // A pop coinciding with flush is not taken; flush already blocks accept via in_ready.
  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= EMPTY;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: if (accept) state_next = ONE;
        ONE: begin
          if (!accept && pop) state_next = EMPTY;
`ifdef PIPE_SKID_REG_SKID_EN
          if (accept && !pop) state_next = FULL;
`endif
        end
        FULL:    if (pop) state_next = ONE;
        default: state_next = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (state_reg != EMPTY);
`ifdef PIPE_SKID_REG_SKID_EN
    in_ready  = rst && !flush && (state_reg != FULL);
`else
    in_ready  = rst && !flush && (!out_valid || out_ready);
`endif
  end

`ifdef PIPE_SKID_REG_SKID_EN
  logic [DATA_W-1:0] skid_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_reg <= '0;
    end else if (flush) begin
      if (CLR_ON_FLUSH) skid_reg <= '0;
    end else if (accept && (state_reg == ONE) && !pop) begin
      skid_reg <= in_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_reg <= '0;
    end else if (flush) begin
      if (CLR_ON_FLUSH) out_data_reg <= '0;
`ifdef PIPE_SKID_REG_SKID_EN
    end else if (state_reg == FULL) begin
      if (pop) out_data_reg <= skid_reg;
`endif
    end else if (accept && (!out_valid || pop)) begin
      out_data_reg <= in_data;
    end
  end

  // Saturating count of stall cycles; flush cycles still count when they stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign out_data  = out_data_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg (CNT_W=4); adapts to PIPE_SKID_REG_SKID_EN.
module tb_pipe_skid_reg;

`ifdef PIPE_SKID_REG_SKID_EN
  localparam logic SKID = 1'b1;
`else
  localparam logic SKID = 1'b0;
`endif

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [3:0]  stall_cnt;

  int          tests = 0;
  int          failed = 0;
  logic        acc, pop, ir_seen, exp_ok;
  logic [31:0] pop_data, exp_data;
  logic [31:0] sb[$];

  pipe_skid_reg #(.DATA_W(32), .CNT_W(4), .CLR_ON_FLUSH(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // Called at a negedge: drive one cycle, record handshakes, keep the scoreboard, return at next negedge.
  task automatic tick(input logic v, input logic [31:0] d, input logic ordy, input logic fl);
    in_valid = v; in_data = d; out_ready = ordy; flush = fl;
    #1;
    ir_seen  = in_ready;
    acc      = in_valid && in_ready;
    pop      = out_valid && out_ready && !flush;
    pop_data = out_data;
    exp_ok   = 1'b0;
    exp_data = '0;
    if (pop && sb.size() > 0) begin
      exp_ok   = 1'b1;
      exp_data = sb.pop_front();
    end
    if (fl) sb.delete();
    else if (acc) sb.push_back(d);
    if (acc) $display("[TB] t=%0t accept %h", $time, d);
    if (pop) $display("[TB] t=%0t emit   %h", $time, pop_data);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'h5A; out_ready = 1'b1;
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (out_data !== 32'h0) begin failed++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    tests++; if (stall_cnt !== 4'd0) begin failed++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_streaming();
    int npop = 0, first = -1, last = -1;
    apply_reset();
    for (int i = 1; i <= 11; i++) begin
      if (i <= 8) tick(1'b1, 32'(i), 1'b1, 1'b0);
      else        tick(1'b0, 32'h0, 1'b1, 1'b0);
      if (pop) begin
        npop++;
        if (first < 0) first = i;
        last = i;
        tests++;
        if (!exp_ok || pop_data !== exp_data) begin
          failed++; $display("FAIL stream_data: got %h want %h (expected_present=%b)", pop_data, exp_data, exp_ok);
        end
      end
    end
    tests++; if (npop != 8) begin failed++; $display("FAIL stream_count: got %0d want 8", npop); end
    tests++; if (first != 2 || last != 9) begin failed++; $display("FAIL stream_timing: got %0d..%0d want 2..9", first, last); end
    tests++; if (stall_cnt !== 4'd0) begin failed++; $display("FAIL stream_stall: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_backpressure();
    int npop = 0;
    apply_reset();
    tick(1'b1, 32'hA, 1'b0, 1'b0);
`ifdef PIPE_SKID_REG_SKID_EN
    tick(1'b1, 32'hB, 1'b0, 1'b0);
    tests++; if (acc !== 1'b1) begin failed++; $display("FAIL bp_skid_accept: got %b want 1", acc); end
    repeat (3) tick(1'b0, 32'h0, 1'b0, 1'b0);
`else
    repeat (4) begin
      tick(1'b1, 32'hB, 1'b0, 1'b0);
      tests++; if (acc !== 1'b0) begin failed++; $display("FAIL bp_hold_accept: got %b want 0", acc); end
    end
`endif
    tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    tests++; if (out_valid !== 1'b1 || out_data !== 32'hA) begin
      failed++; $display("FAIL bp_hold: got v=%b d=%h want v=1 d=a", out_valid, out_data);
    end
    tests++; if (stall_cnt !== 4'd4) begin failed++; $display("FAIL bp_stall: got %0d want 4", stall_cnt); end
    for (int i = 0; i < 3; i++) begin
      if (i == 0) tick(SKID ? 1'b0 : 1'b1, SKID ? 32'h0 : 32'hB, 1'b1, 1'b0);
      else        tick(1'b0, 32'h0, 1'b1, 1'b0);
      if (pop) begin
        npop++;
        tests++;
        if (!exp_ok || pop_data !== exp_data) begin
          failed++; $display("FAIL bp_order: got %h want %h (expected_present=%b)", pop_data, exp_data, exp_ok);
        end
      end
    end
    tests++; if (npop != 2) begin failed++; $display("FAIL bp_count: got %0d want 2", npop); end
    tests++; if (stall_cnt !== 4'd4) begin failed++; $display("FAIL bp_stall_after: got %0d want 4", stall_cnt); end
  endtask

  task automatic test_flush();
    int npop = 0;
    apply_reset();
    tick(1'b1, 32'hA, 1'b0, 1'b0);
    tick(1'b1, 32'hB, 1'b0, 1'b0);
    tick(1'b1, 32'hC, 1'b0, 1'b1);
    tests++; if (ir_seen !== 1'b0) begin failed++; $display("FAIL flush_in_ready: got %b want 0", ir_seen); end
    tests++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      failed++; $display("FAIL flush_clear: got v=%b d=%h want v=0 d=0", out_valid, out_data);
    end
    tests++; if (stall_cnt !== 4'd2) begin failed++; $display("FAIL flush_stall: got %0d want 2", stall_cnt); end
    repeat (3) begin
      tick(1'b0, 32'h0, 1'b1, 1'b0);
      tests++; if (pop !== 1'b0) begin failed++; $display("FAIL flush_leak: got pop of %h want none", pop_data); end
    end
    tests++; if (stall_cnt !== 4'd2) begin failed++; $display("FAIL flush_stall_hold: got %0d want 2", stall_cnt); end
    tick(1'b1, 32'hE, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 32'h0, 1'b1, 1'b0);
      if (pop) begin
        npop++;
        tests++;
        if (!exp_ok || pop_data !== exp_data) begin
          failed++; $display("FAIL flush_after: got %h want %h (expected_present=%b)", pop_data, exp_data, exp_ok);
        end
      end
    end
    tests++; if (npop != 1) begin failed++; $display("FAIL flush_after_count: got %0d want 1", npop); end
  endtask

  task automatic test_saturation();
    logic [3:0] want;
    apply_reset();
    tick(1'b1, 32'h5, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      tick(1'b0, 32'h0, 1'b0, 1'b0);
      want = (k > 15) ? 4'd15 : 4'(k);
      tests++; if (stall_cnt !== want) begin failed++; $display("FAIL sat_cycle%0d: got %0d want %0d", k, stall_cnt, want); end
    end
    tick(1'b0, 32'h0, 1'b1, 1'b0);
    tests++;
    if (!pop || !exp_ok || pop_data !== exp_data) begin
      failed++; $display("FAIL sat_drain: got pop=%b d=%h want %h", pop, pop_data, exp_data);
    end
    tests++; if (stall_cnt !== 4'd15) begin failed++; $display("FAIL sat_final: got %0d want 15", stall_cnt); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    tick(1'b1, 32'hA, 1'b0, 1'b0);
    tick(1'b1, 32'hB, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || stall_cnt !== 4'd0) begin
      failed++; $display("FAIL arst_now: got v=%b cnt=%0d want v=0 cnt=0", out_valid, stall_cnt);
    end
    tests++; if (out_data !== 32'h0 || in_ready !== 1'b0) begin
      failed++; $display("FAIL arst_data: got d=%h rdy=%b want d=0 rdy=0", out_data, in_ready);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    tick(1'b1, 32'h77, 1'b1, 1'b0);
    tests++; if (pop !== 1'b0) begin failed++; $display("FAIL arst_first_edge: got pop of %h want none", pop_data); end
    tick(1'b0, 32'h0, 1'b1, 1'b0);
    tests++;
    if (!pop || !exp_ok || pop_data !== 32'h77) begin
      failed++; $display("FAIL arst_first_out: got pop=%b d=%h want 77", pop, pop_data);
    end
  endtask

  task automatic test_ready_path();
    apply_reset();
    tick(1'b1, 32'h11, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      out_ready = i[0];
      #1;
      tests++;
      if (in_ready !== (SKID | i[0])) begin
        failed++; $display("FAIL ready_one_r%0d: got %b want %b", i[0], in_ready, SKID | i[0]);
      end
    end
    tick(1'b1, 32'h22, 1'b0, 1'b0);
    tests++;
    if (sb.size() != (SKID ? 2 : 1)) begin
      failed++; $display("FAIL ready_occupancy: got %0d want %0d", sb.size(), SKID ? 2 : 1);
    end
    for (int i = 0; i < 2; i++) begin
      out_ready = i[0];
      #1;
      tests++;
      if (in_ready !== (!SKID & i[0])) begin
        failed++; $display("FAIL ready_held_r%0d: got %b want %b", i[0], in_ready, !SKID & i[0]);
      end
    end
    repeat (3) begin
      tick(1'b0, 32'h0, 1'b1, 1'b0);
      if (pop) begin
        tests++;
        if (!exp_ok || pop_data !== exp_data) begin
          failed++; $display("FAIL ready_drain: got %h want %h (expected_present=%b)", pop_data, exp_data, exp_ok);
        end
      end
    end
    tests++; if (sb.size() != 0 || out_valid !== 1'b0) begin
      failed++; $display("FAIL ready_empty: got left=%0d v=%b want 0 0", sb.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_saturation();
    test_async_reset();
    test_ready_path();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
